// File: rtl/matmul2x2_k2.sv
// 2x2 by 2x2 signed matrix multiplier, one MAC per element, K stepped over two cycles.
// Operands are captured on start; C and done are registered and held in DONE.
module matmul2x2_k2 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [1:0][1:0][DATA_W-1:0]    A,
  input  logic [1:0][1:0][DATA_W-1:0]    B,
  output logic [1:0][1:0][ACC_W-1:0]     C,
  output logic                           done
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC0,
    S_MAC1,
    S_DONE
  } state_t;

  state_t                       r_state;
  logic [1:0][1:0][DATA_W-1:0]  r_aq;
  logic [1:0][1:0][DATA_W-1:0]  r_bq;
  logic [1:0][1:0][ACC_W-1:0]   r_acc;
  logic [1:0][1:0][ACC_W-1:0]   r_c;
  logic                         r_done;

  logic                         w_k;
  logic [1:0][1:0][ACC_W-1:0]   w_sum;

  assign C    = r_c;
  assign done = r_done;
  assign w_k  = (r_state == S_MAC1);

  // Four parallel MACs; the k index follows the MAC state.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        logic [DATA_W-1:0] v_a;
        logic [DATA_W-1:0] v_b;
        logic [PW-1:0]     v_ae;
        logic [PW-1:0]     v_be;
        logic [PW-1:0]     v_p;
        v_a  = r_aq[i][w_k];
        v_b  = r_bq[w_k][j];
        v_ae = {{DATA_W{v_a[DATA_W-1]}}, v_a};
        v_be = {{DATA_W{v_b[DATA_W-1]}}, v_b};
        v_p  = PW'($signed(v_ae) * $signed(v_be));
        w_sum[i][j] = r_acc[i][j]
                    + {{(ACC_W-PW){v_p[PW-1]}}, v_p};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_aq    <= '0;
      r_bq    <= '0;
      r_acc   <= '0;
      r_c     <= '0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_aq    <= A;
            r_bq    <= B;
            r_acc   <= '0;
            r_state <= S_MAC0;
          end
        end
        S_MAC0: begin
          r_acc   <= w_sum;
          r_state <= S_MAC1;
        end
        S_MAC1: begin
          r_acc   <= w_sum;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle publishes the result; later cycles wait for start low.
          if (!r_done) begin
            r_c    <= r_acc;
            r_done <= 1'b1;
          end else if (!start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul2x2_k2.sv
// Scoreboard bench for matmul2x2_k2.
// Expected matrices come from an integer model pushed at stimulus time.
module tb_matmul2x2_k2;

  typedef logic [1:0][1:0][7:0]  omat_t;
  typedef logic [1:0][1:0][31:0] cmat_t;

  logic  clk;
  logic  rst_n;
  logic  start;
  omat_t A;
  omat_t B;
  cmat_t C;
  logic  done;

  int    n_chk;
  int    n_fail;
  cmat_t sb_q[$];
  cmat_t last_c;

  matmul2x2_k2 #(
    .DATA_W(8),
    .ACC_W (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .C    (C),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic cmat_t model(omat_t a, omat_t b);
    cmat_t r;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 2; k++) begin
          int x;
          int y;
          x = int'($signed(a[i][k]));
          y = int'($signed(b[k][j]));
          s += x * y;
        end
        r[i][j] = 32'(s);
      end
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run(omat_t a, omat_t b, omat_t a2, omat_t b2, int hold);
    int    n;
    bit    got;
    cmat_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    chk("busy_done", 128'(done), 128'(0));
    chk("busy_c", C, last_c);
    @(negedge clk);
    A = a2;
    B = b2;
    n = 0;
    got = 1'b0;
    while (n < 8 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
      else chk("hold_c", C, last_c);
    end
    chk("latency", 128'(n), 128'(3));
    e = sb_q.pop_front();
    if (got) begin
      chk("result", C, e);
      last_c = e;
    end else begin
      chk("done_timeout", 128'(0), 128'(1));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("done_held", 128'(done), 128'(1));
      chk("c_held", C, last_c);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_fall", 128'(done), 128'(0));
    chk("c_after", C, last_c);
  endtask

  task automatic reset_in_mac1(omat_t a, omat_t b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_c", C, '0);
    chk("rst_done", 128'(done), 128'(0));
    start = 1'b0;
    last_c = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("no_done", 128'(done), 128'(0));
    end
    chk("post_rst_c", C, '0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    last_c = '0;
    rst_n  = 1'b0;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_c", C, '0);
    chk("reset_done", 128'(done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run(32'h04030201, 32'h08070605, 32'h04030201, 32'h08070605, 3);
    chk("basic_val", C, {32'd50, 32'd43, 32'd22, 32'd19});
    run(32'h01000001, 32'h02020202, 32'h7f7f7f7f, 32'h80808080, 0);
    chk("ident_val", C, {4{32'd2}});
    run(32'h80808080, 32'h80808080, 32'h00000000, 32'h00000000, 1);
    chk("neg_neg", C, {4{32'd32768}});
    run(32'h80808080, 32'h7f7f7f7f, 32'h01010101, 32'h01010101, 0);
    chk("neg_pos", C, {4{-32'sd32512}});
    run(32'h04030201, 32'h08070605, 32'h0, 32'h0, 0);
    run(32'h01000001, 32'h02020202, 32'hffffffff, 32'h11223344, 0);

    for (int t = 0; t < 4; t++) begin
      omat_t ra;
      omat_t rb;
      ra = $urandom;
      rb = $urandom;
      run(ra, rb, omat_t'($urandom), omat_t'($urandom), t);
    end

    reset_in_mac1(32'h04030201, 32'h08070605);
    run(32'h7f7f7f7f, 32'h7f7f7f7f, 32'h0, 32'h0, 0);
    chk("pos_pos", C, {4{32'd32258}});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
